// File: rtl/fetch.sv
// fetch: line-buffered 2x2 neighbourhood fetch for LUT-driven image remapping.
// Video lines are written into a circular buffer of buf_lines lines. Each LUT
// entry selects a source column and a row offset. The four neighbours
// (r0,x) (r0,x+1) (r1,x) (r1,x+1) come out two cycles after the LUT handshake.
// Optional feature macro: FETCH_BORDER_ZERO_EN. When it is defined, neighbours
// outside the image read as zero instead of being clamped to the edge.
module fetch #(
  parameter int img_width  = 16,
  parameter int img_height = 16,
  parameter int buf_lines  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vtvalid,
  input  logic [7:0] vtdata,
  input  logic       vtlast,
  output logic       vtready,
  input  logic       ltvalid,
  input  logic [7:0] ltdata,
  input  logic       ltlast,
  output logic       ltready,
  output logic [7:0] lu,
  output logic [7:0] ru,
  output logic [7:0] ld,
  output logic [7:0] rd,
  output logic       ovalid
);

  localparam int RW    = $clog2(img_height + 1);
  localparam int CW    = (img_width > 1) ? $clog2(img_width) : 1;
  localparam int DEPTH = buf_lines * img_width;
  localparam int AW    = $clog2(DEPTH);
  localparam int MAXDY = buf_lines - 2;

  // Frame bookkeeping.
  logic          active_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] wr_row_reg;
  logic [RW-1:0] out_row_reg;

  logic          wr_en;
  logic          lt_fire;
  logic          frame_done;
  logic [AW-1:0] wr_addr;

  // Read port order: 0=(r0,x) 1=(r0,x1) 2=(r1,x) 3=(r1,x1).
  logic [AW-1:0] rd_addr [4];
  logic [3:0]    zero_next;
  logic [7:0]    bank_q [4];

  // Pipeline stages behind the buffer read.
  logic       s1_valid_reg;
  logic [3:0] s1_zero_reg;
  logic       s2_valid_reg;
  logic [3:0] s2_zero_reg;
  logic [7:0] s2_data_reg [4];

  // Flow control: writer may not overtake the oldest line a LUT entry can still reach.
  always_comb begin : ready_calc
    int wr_i;
    int out_i;
    int oldest_i;
    int need_i;
    wr_i     = int'(wr_row_reg);
    out_i    = int'(out_row_reg);
    oldest_i = (out_i > MAXDY) ? out_i - MAXDY : 0;
    need_i   = (out_i + 2 < img_height) ? out_i + 2 : img_height;
    vtready  = active_reg && (wr_i < img_height) && ((wr_i - oldest_i) < buf_lines);
    ltready  = active_reg && (wr_i >= need_i) && (out_i < img_height);
  end

  assign wr_en      = vtvalid && vtready;
  assign lt_fire    = ltvalid && ltready;
  assign frame_done = (out_row_reg == RW'(img_height)) && (wr_row_reg == RW'(img_height));
  assign wr_addr    = AW'((int'(wr_row_reg) % buf_lines) * img_width + int'(col_reg));

  // Turn a LUT entry into four buffer addresses plus per-neighbour border flags.
  always_comb begin : lut_calc
    int x_i;
    int dy_i;
    int top_i;
    int r0_i;
    int r1_i;
    int x1_i;
    x_i = int'(ltdata[3:0]);
    if (x_i > img_width - 1) x_i = img_width - 1;
    dy_i = int'(ltdata[7:4]);
    if (dy_i > MAXDY) dy_i = MAXDY;
    top_i = int'(out_row_reg) - dy_i;
    r0_i  = (top_i < 0) ? 0 : top_i;
    r1_i  = (r0_i + 1 > img_height - 1) ? img_height - 1 : r0_i + 1;
    x1_i  = (x_i + 1 > img_width - 1) ? img_width - 1 : x_i + 1;
    rd_addr[0] = AW'((r0_i % buf_lines) * img_width + x_i);
    rd_addr[1] = AW'((r0_i % buf_lines) * img_width + x1_i);
    rd_addr[2] = AW'((r1_i % buf_lines) * img_width + x_i);
    rd_addr[3] = AW'((r1_i % buf_lines) * img_width + x1_i);
    zero_next = '0;
`ifdef FETCH_BORDER_ZERO_EN
    if (top_i < 0) begin
      zero_next[0] = 1'b1;
      zero_next[1] = 1'b1;
    end
    if ((top_i + 1 < 0) || (top_i + 1 > img_height - 1)) begin
      zero_next[2] = 1'b1;
      zero_next[3] = 1'b1;
    end
    if (x_i + 1 > img_width - 1) begin
      zero_next[1] = 1'b1;
      zero_next[3] = 1'b1;
    end
`endif
  end

  // Four identical buffer copies so all neighbours are read in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bank
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;
      // Shared write, private registered read; same-address read sees old data.
      always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= vtdata;
        if (lt_fire) q_reg <= mem[rd_addr[gi]];
      end
      assign bank_q[gi] = q_reg;
    end
  endgenerate

  // Column/line counters and frame turnover.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg  <= 1'b0;
      col_reg     <= '0;
      wr_row_reg  <= '0;
      out_row_reg <= '0;
    end else begin
      active_reg <= 1'b1;
      if (frame_done) begin
        col_reg     <= '0;
        wr_row_reg  <= '0;
        out_row_reg <= '0;
      end else begin
        if (wr_en) begin
          if (vtlast || (col_reg == CW'(img_width - 1))) begin
            col_reg    <= '0;
            wr_row_reg <= wr_row_reg + 1'b1;
          end else begin
            col_reg <= col_reg + 1'b1;
          end
        end
        if (lt_fire && ltlast) out_row_reg <= out_row_reg + 1'b1;
      end
    end
  end

  // Valid/border pipeline and output registers; outputs hold while ovalid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_zero_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_zero_reg  <= '0;
      ovalid       <= 1'b0;
      lu           <= '0;
      ru           <= '0;
      ld           <= '0;
      rd           <= '0;
    end else begin
      s1_valid_reg <= lt_fire;
      if (lt_fire) s1_zero_reg <= zero_next;
      s2_valid_reg <= s1_valid_reg;
      s2_zero_reg  <= s1_zero_reg;
      ovalid       <= s2_valid_reg;
      if (s2_valid_reg) begin
        lu <= s2_zero_reg[0] ? 8'h00 : s2_data_reg[0];
        ru <= s2_zero_reg[1] ? 8'h00 : s2_data_reg[1];
        ld <= s2_zero_reg[2] ? 8'h00 : s2_data_reg[2];
        rd <= s2_zero_reg[3] ? 8'h00 : s2_data_reg[3];
      end
    end
  end

  // Data stage between buffer read and output; qualified by the valid pipeline.
  always_ff @(posedge clk) begin
    if (s1_valid_reg) begin
      for (int i = 0; i < 4; i++) s2_data_reg[i] <= bank_q[i];
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized and directed stimulus for fetch, checked every cycle
// against a frame-level model (full image array, spec row/column rules).
module tb_fetch;
  localparam int W = 16;
  localparam int H = 16;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vtvalid = 1'b0;
  logic [7:0] vtdata = 8'h00;
  logic       vtlast = 1'b0;
  logic       vtready;
  logic       ltvalid = 1'b0;
  logic [7:0] ltdata = 8'h00;
  logic       ltlast = 1'b0;
  logic       ltready;
  logic [7:0] lu, ru, ld, rd;
  logic       ovalid;

  always #5 clk = ~clk;

  fetch #(.img_width(W), .img_height(H), .buf_lines(B)) dut (
    .clk(clk), .rst(rst),
    .vtvalid(vtvalid), .vtdata(vtdata), .vtlast(vtlast), .vtready(vtready),
    .ltvalid(ltvalid), .ltdata(ltdata), .ltlast(ltlast), .ltready(ltready),
    .lu(lu), .ru(ru), .ld(ld), .rd(rd), .ovalid(ovalid)
  );

  typedef struct {
    int          due;
    logic [31:0] pix;
  } exp_t;

  int          n_vec = 0;
  int          n_miscmp = 0;
  int          cyc = 0;
  int          beats = 0;
  int          n_out = 0;
  int          m_wr = 0;
  int          m_col = 0;
  int          m_out = 0;
  bit          m_active = 1'b0;
  logic [7:0]  img [H][W];
  exp_t        expq [$];
  logic [31:0] last_pix = 32'h0;
  bit          vid_on = 1'b0;
  bit          lut_rand = 1'b0;
  int          vid_pct = 100;
  bit          vt_took = 1'b0;
  bit          lt_took = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_vt();
    int oldest;
    oldest = (m_out > B - 2) ? m_out - (B - 2) : 0;
    return m_active && (m_wr < H) && ((m_wr - oldest) < B);
  endfunction

  function automatic bit exp_lt();
    int need;
    need = (m_out + 2 < H) ? m_out + 2 : H;
    return m_active && (m_wr >= need) && (m_out < H);
  endfunction

  // Expected {lu,ru,ld,rd} from the image as written so far.
  function automatic logic [31:0] ref_pix(input logic [7:0] d);
    int x, dy, top, r0, r1, x1;
    logic [7:0] p0, p1, p2, p3;
    x  = int'(d[3:0]);
    if (x > W - 1) x = W - 1;
    dy = int'(d[7:4]);
    if (dy > B - 2) dy = B - 2;
    top = m_out - dy;
    r0 = (top < 0) ? 0 : top;
    r1 = (r0 + 1 > H - 1) ? H - 1 : r0 + 1;
    x1 = (x + 1 > W - 1) ? W - 1 : x + 1;
    p0 = img[r0][x];
    p1 = img[r0][x1];
    p2 = img[r1][x];
    p3 = img[r1][x1];
`ifdef FETCH_BORDER_ZERO_EN
    if (top < 0) begin p0 = 8'h00; p1 = 8'h00; end
    if ((top + 1 < 0) || (top + 1 > H - 1)) begin p2 = 8'h00; p3 = 8'h00; end
    if (x + 1 > W - 1) begin p1 = 8'h00; p3 = 8'h00; end
`endif
    return {p0, p1, p2, p3};
  endfunction

  // One clock: drive sources, update the model at the edge, check at negedge.
  task automatic cycle();
    bit vf, lf, r, done;
    logic [31:0] ep;
    if (!vid_on) vtvalid = 1'b0;
    else if (!vtvalid || vt_took) vtvalid = (m_wr < H) && ($urandom_range(0, 99) < vid_pct);
    vtdata = 8'(m_wr * 16 + m_col);
    vtlast = (m_col == W - 1);
    if (lut_rand && (!ltvalid || lt_took)) begin
      ltvalid = ($urandom_range(0, 1) == 1);
      ltdata  = 8'($urandom);
      ltlast  = ($urandom_range(0, 2) == 0);
    end
    vf   = vtvalid && vtready;
    lf   = ltvalid && ltready;
    r    = rst;
    done = (m_out == H) && (m_wr == H);
    ep   = ref_pix(ltdata);
    @(posedge clk);
    cyc++;
    vt_took = vf && !r;
    lt_took = lf && !r;
    if (r) begin
      m_wr = 0; m_col = 0; m_out = 0; m_active = 1'b0;
      expq.delete();
      last_pix = 32'h0;
    end else begin
      m_active = 1'b1;
      if (done) begin
        m_wr = 0; m_col = 0; m_out = 0;
      end else begin
        if (vf) begin
          beats++;
          img[m_wr][m_col] = vtdata;
          if (vtlast || m_col == W - 1) begin m_col = 0; m_wr++; end
          else m_col++;
        end
        if (lf) begin
          expq.push_back('{due: cyc + 2, pix: ep});
          if (ltlast) m_out++;
        end
      end
    end
    @(negedge clk);
    if (expq.size() > 0 && expq[0].due == cyc) begin
      last_pix = expq[0].pix;
      void'(expq.pop_front());
      n_out++;
      $display("entry %0d @%0d: lu=%h ru=%h ld=%h rd=%h", n_out, cyc, lu, ru, ld, rd);
      check("ovalid", 32'(ovalid), 32'd1);
    end else begin
      check("ovalid", 32'(ovalid), 32'd0);
    end
    check("pix", {lu, ru, ld, rd}, last_pix);
    check("vtready", 32'(vtready), 32'(exp_vt()));
    check("ltready", 32'(ltready), 32'(exp_lt()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Present one LUT entry and hold it until accepted (bounded).
  task automatic lut(input logic [7:0] d, input bit last);
    bit fired;
    fired = 1'b0;
    ltvalid = 1'b1;
    ltdata  = d;
    ltlast  = last;
    for (int n = 0; n < 400 && !fired; n++) begin
      fired = ltready;
      cycle();
    end
    check("lut_accept", 32'(fired), 32'd1);
    ltvalid = 1'b0;
    ltlast  = 1'b0;
  endtask

  task automatic stream_beats(input int target);
    vid_on = 1'b1;
    vid_pct = 100;
    for (int n = 0; n < 400 && beats < target; n++) cycle();
    vid_on = 1'b0;
    check("stream_beats", 32'(beats), 32'(target));
  endtask

  initial begin
    logic [31:0] exp21, exp23;
`ifdef FETCH_BORDER_ZERO_EN
    exp21 = 32'h0F001F00;
    exp23 = 32'hF5F60000;
`else
    exp21 = 32'h0F0F1F1F;
    exp23 = 32'hF5F6F5F6;
`endif
    rst = 1'b1;
    run(3);
    check("reset_pix", {lu, ru, ld, rd}, 32'h0);
    check("reset_vtready", 32'(vtready), 32'd0);
    rst = 1'b0;
    run(1);
    check("first_vtready", 32'(vtready), 32'd1);

    // Two lines, then a single entry on row 0 with exact latency.
    stream_beats(32);
    lut(8'h03, 1'b0);
    run(1);
    check("lat1_ovalid", 32'(ovalid), 32'd0);
    run(1);
    check("lat2_ovalid", 32'(ovalid), 32'd1);
    check("row0_x3", {lu, ru, ld, rd}, 32'h03041314);
    lut(8'h0F, 1'b0);
    run(2);
    check("row0_x15", {lu, ru, ld, rd}, exp21);

    // Unthrottled video with no LUT traffic stops after four lines.
    vid_on = 1'b1;
    run(40);
    check("fill_beats", 32'(beats), 32'd64);
    check("fill_vtready", 32'(vtready), 32'd0);

    // Advance to row 5 and exercise the row offset with saturation.
    for (int i = 0; i < 5; i++) lut(8'h00, 1'b1);
    lut(8'h27, 1'b0);
    run(2);
    check("row5_dy2", {lu, ru, ld, rd}, 32'h37384748);
    lut(8'h97, 1'b0);
    run(2);
    check("row5_dy9", {lu, ru, ld, rd}, 32'h37384748);

    // Last row: lower neighbours clamp to row 15.
    for (int i = 0; i < 20 && m_out < 15; i++) lut(8'h00, 1'b1);
    lut(8'h05, 1'b0);
    run(2);
    check("row15_x5", {lu, ru, ld, rd}, exp23);
    lut(8'h00, 1'b1);
    for (int i = 0; i < 300 && !(m_out == 0 && m_wr == 0); i++) cycle();
    check("wrap_vtready", 32'(vtready), 32'd1);

    // Random traffic across frame boundaries.
    vid_on = 1'b1;
    vid_pct = 70;
    lut_rand = 1'b1;
    run(1500);

    // Reset in the middle of a frame.
    for (int i = 0; i < 3000 && m_wr != 3; i++) cycle();
    check("reach_row3", 32'(m_wr), 32'd3);
    rst = 1'b1;
    run(1);
    check("midrst_pix", {lu, ru, ld, rd}, 32'h0);
    check("midrst_ovalid", 32'(ovalid), 32'd0);
    check("midrst_ltready", 32'(ltready), 32'd0);
    rst = 1'b0;
    lut_rand = 1'b0;
    ltvalid = 1'b0;
    vid_on = 1'b0;
    run(1);
    beats = 0;
    stream_beats(32);
    lut(8'h03, 1'b0);
    run(2);
    check("restart_x3", {lu, ru, ld, rd}, 32'h03041314);

    vid_on = 1'b1;
    vid_pct = 80;
    lut_rand = 1'b1;
    run(1500);
    lut_rand = 1'b0;
    ltvalid = 1'b0;
    run(4);
    check("drain", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameters: img_width, 16, pixels per line, range 2..16; img_height, 16, lines per frame; buf_lines, 4, line-buffer depth in lines, minimum 3.
REQ-002 Ports, in order:
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- vtvalid  in  1  video pixel valid.
- vtdata  in  8  video pixel.
- vtlast  in  1  last pixel of video line.
- vtready  out  1  video accept.
- ltvalid  in  1  LUT entry valid.
- ltdata  in  8  LUT entry: [3:0] source column x, [7:4] row offset dy.
- ltlast  in  1  last LUT entry of output row.
- ltready  out  1  LUT accept.
- lu  out  8  upper-left neighbour pixel.
- ru  out  8  upper-right neighbour pixel.
- ld  out  8  lower-left neighbour pixel.
- rd  out  8  lower-right neighbour pixel.
- ovalid  out  1  lu/ru/ld/rd valid this cycle.

Function
REQ-003 Transfers follow AXI-stream rules: a beat transfers on a rising edge with valid and ready both high; data is held by the source until then.
REQ-004 Video pixels are written to a circular buffer of buf_lines lines x img_width bytes; the column counter increments per beat and clears on vtlast or after column img_width-1, whichever comes first; the line counter wr_row then increments.
REQ-005 Unwritten columns of a short line keep stale contents; pixels beyond img_width-1 without vtlast start the next line.
REQ-006 vtready is high when wr_row < img_height and wr_row - max(0, out_row - (buf_lines-2)) < buf_lines, so no line still needed is overwritten.
REQ-007 ltready is high when wr_row >= min(out_row+2, img_height) and out_row < img_height.
REQ-008 For each accepted LUT entry: x = ltdata[3:0] clamped to img_width-1; dy = ltdata[7:4] saturated to buf_lines-2.
REQ-009 Source rows: r0 = max(out_row - dy, 0); r1 = min(r0+1, img_height-1). Column x1 = min(x+1, img_width-1).
REQ-010 Outputs: lu=P(r0,x), ru=P(r0,x1), ld=P(r1,x), rd=P(r1,x1).
REQ-011 Outputs register exactly 2 cycles after the LUT handshake, with ovalid high for one cycle per entry; the block sustains one entry per cycle.
REQ-012 ovalid low leaves lu/ru/ld/rd at their last values.
REQ-013 ltlast on an accepted beat increments out_row.
REQ-014 When out_row reaches img_height, and wr_row equals img_height, both counters clear in the next cycle for the next frame.
REQ-015 A simultaneous video write and LUT read to the same buffer location returns the old data.

Reset
REQ-016 While rst is high at a clock edge: counters clear, the pipeline is flushed, vtready=ltready=ovalid=0 and lu=ru=ld=rd=0.
REQ-017 On the first edge with rst low, vtready rises.
REQ-018 A reset mid-frame discards the frame and all in-flight entries.

Configuration
REQ-019 Macro FETCH_BORDER_ZERO_EN.
- Defined: any neighbour whose unclamped row (out_row-dy, or that +1) or column (x+1) falls outside the image outputs 0.
- Undefined: edge clamping per REQ-009.

Verification
All scenarios use defaults; video pixel P(r,c) = r*16+c (mod 256).
REQ-020 Release reset, stream 2 lines; then LUT {dy=0,x=3} with out_row=0 -> lu=0x03, ru=0x04, ld=0x13, rd=0x14, ovalid exactly 2 cycles after the handshake.
REQ-021 LUT x=15 on row 0 -> ru=0x0F, rd=0x1F (clamp); with FETCH_BORDER_ZERO_EN -> ru=rd=0x00.
REQ-022 Video streamed continuously with no LUT traffic -> vtready drops after 4 lines (64 beats) and stays low until LUT rows advance.
REQ-023 Row 5, LUT {dy=2,x=7} -> lu=0x37, ld=0x47; dy=9 saturates to 2 -> same result; at out_row=15 -> ld=rd from row 15.
REQ-024 Assert rst mid-frame (row 3) -> all outputs 0 the next cycle; a new frame restarts at row 0 with correct values.
